// File: rtl/config_pkg.sv
// -----------------------------------------------------------------------------
// config_pkg
// Shared configuration for the FPU conversion post-processing slice.
//   CVTLEN       : conversion length (integer width handled by the converter)
//   NF           : fraction bits of the widest floating-point format
//   CVTSHIFTLEN  : width of the conversion shift-input vector
//   CVTSHIFTSTEP : bit positions the sequential shifter advances per cycle
//   cvt_state_t  : control states of the sequential conversion shifter
// -----------------------------------------------------------------------------
package config_pkg;

    localparam int CVTLEN       = 64;
    localparam int NF           = 52;
    localparam int CVTSHIFTLEN  = CVTLEN + NF + 1;
    localparam int CVTSHIFTSTEP = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } cvt_state_t;

endpackage

// File: rtl/cvt_shift_step.sv
// -----------------------------------------------------------------------------
// cvt_shift_step
// One iteration of the sequential left shifter (purely combinational).
// Shifts the current vector left by k = min(cur_rem, STEP) and returns the
// remaining distance cur_rem - k. Built as log2(STEP)+1 binary mux stages,
// stage g shifting by 2**g when bit g of k is set.
// Ports:
//   cur_vec  [W-1:0] : vector before this iteration
//   cur_rem  [SW:0]  : remaining shift distance before this iteration
//   nxt_vec  [W-1:0] : cur_vec << k, truncated to W bits
//   nxt_rem  [SW:0]  : cur_rem - k
// -----------------------------------------------------------------------------
module cvt_shift_step #(
    parameter int W    = 117,
    parameter int SW   = 7,
    parameter int STEP = 16
) (
    input  logic [W-1:0] cur_vec,
    input  logic [SW:0]  cur_rem,
    output logic [W-1:0] nxt_vec,
    output logic [SW:0]  nxt_rem
);

    localparam int RW = SW + 1;
    // k never exceeds STEP, so KW bits of it drive the mux stages
    localparam int KW = $clog2(STEP) + 1;
    localparam logic [RW-1:0] STEP_C = RW'(STEP);

    logic [RW-1:0] take_s;
    logic [W-1:0]  stage_s [KW+1];

    // Distance covered by this iteration: the remainder, capped at STEP
    always_comb begin
        take_s = cur_rem;
        if (cur_rem > STEP_C) begin
            take_s = STEP_C;
        end else begin
            take_s = cur_rem;
        end
    end

    assign stage_s[0] = cur_vec;

    for (genvar g = 0; g < KW; g++) begin : g_stage
        assign stage_s[g+1] = take_s[g] ? (stage_s[g] << (1 << g)) : stage_s[g];
    end

    assign nxt_vec = stage_s[KW];
    assign nxt_rem = cur_rem - take_s;

endmodule

// File: rtl/cvt_shift_seq.sv
// -----------------------------------------------------------------------------
// cvt_shift_seq
// Iterative replacement for the wide conversion barrel shifter. Accepts the
// conversion shift-input vector, a left-shift amount and the underflow flag,
// shifts at up to STEP positions per cycle and hands the result to rounding
// over a valid/ready handshake. Bits leaving the MSB are discarded.
// Ports:
//   clk       : clock
//   reset_n   : asynchronous active-low reset
//   Flush     : synchronous abort back to IDLE (wins over accept/handshake)
//   InValid   : request valid
//   InReady   : block can accept (IDLE, or DONE with OutReady)
//   ShiftIn   : vector to shift, sampled at accept
//   ShiftAmt  : left-shift amount, sampled at accept, saturates at W
//   ResUfIn   : underflow flag travelling with the request
//   OutValid  : result valid (registered)
//   OutReady  : downstream accepts the result
//   Shifted   : ShiftIn << ShiftAmt truncated to W bits (registered)
//   ResUfOut  : ResUfIn captured at accept (registered)
// -----------------------------------------------------------------------------
module cvt_shift_seq #(
    parameter int CVTLEN = config_pkg::CVTLEN,
    parameter int NF     = config_pkg::NF,
    parameter int W      = CVTLEN + NF + 1,
    parameter int SW     = $clog2(W),
    parameter int STEP   = config_pkg::CVTSHIFTSTEP
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          Flush,
    input  logic          InValid,
    output logic          InReady,
    input  logic [W-1:0]  ShiftIn,
    input  logic [SW-1:0] ShiftAmt,
    input  logic          ResUfIn,
    output logic          OutValid,
    input  logic          OutReady,
    output logic [W-1:0]  Shifted,
    output logic          ResUfOut
);

    import config_pkg::*;

    // Remaining count is one bit wider than ShiftAmt so that W itself fits
    localparam int RW = SW + 1;
    localparam logic [RW-1:0] W_C = RW'(W);

    cvt_state_t    state_r;
    cvt_state_t    state_next_s;
    cvt_state_t    load_state_s;
    logic [RW-1:0] rem_r;
    logic [W-1:0]  shifted_r;
    logic          res_uf_r;
    logic          out_valid_r;
    logic          out_valid_next_s;
    logic          in_ready_s;
    logic          accept_s;
    logic [RW-1:0] amt_ext_s;
    logic [RW-1:0] amt_clamp_s;
    logic [W-1:0]  step_vec_s;
    logic [RW-1:0] step_rem_s;

    cvt_shift_step #(
        .W    (W),
        .SW   (SW),
        .STEP (STEP)
    ) u_step (
        .cur_vec (shifted_r),
        .cur_rem (rem_r),
        .nxt_vec (step_vec_s),
        .nxt_rem (step_rem_s)
    );

    // Saturate the requested shift at W; larger amounts clear the vector
    always_comb begin
        amt_ext_s   = {1'b0, ShiftAmt};
        amt_clamp_s = amt_ext_s;
        if (amt_ext_s > W_C) begin
            amt_clamp_s = W_C;
        end else begin
            amt_clamp_s = amt_ext_s;
        end
    end

    // Handshake: ready depends only on state and OutReady; Flush blocks accept
    always_comb begin
        in_ready_s       = (state_r == IDLE) | ((state_r == DONE) & OutReady);
        accept_s         = InValid & in_ready_s & ~Flush;
        out_valid_next_s = 1'b0;
        if (state_next_s == DONE) begin
            out_valid_next_s = 1'b1;
        end else begin
            out_valid_next_s = 1'b0;
        end
    end

    // State after an accept: a zero shift is complete immediately
    always_comb begin
        load_state_s = SHIFT;
        if (ShiftAmt == {SW{1'b0}}) begin
            load_state_s = DONE;
        end else begin
            load_state_s = SHIFT;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        if (Flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_next_s = load_state_s;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (step_rem_s == {RW{1'b0}}) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = SHIFT;
                    end
                end
                DONE: begin
                    if (!OutReady) begin
                        state_next_s = DONE;
                    end else if (accept_s) begin
                        state_next_s = load_state_s;
                    end else begin
                        state_next_s = IDLE;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end
    end

    // State and valid registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            out_valid_r <= out_valid_next_s;
        end
    end

    // Datapath: load on accept, advance while shifting, hold otherwise
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shifted_r <= {W{1'b0}};
            res_uf_r  <= 1'b0;
            rem_r     <= {RW{1'b0}};
        end else if (Flush) begin
            // Shifted is intentionally left as is; only the count is cleared
            rem_r <= {RW{1'b0}};
        end else if (accept_s) begin
            shifted_r <= ShiftIn;
            res_uf_r  <= ResUfIn;
            rem_r     <= amt_clamp_s;
        end else if (state_r == SHIFT) begin
            shifted_r <= step_vec_s;
            rem_r     <= step_rem_s;
        end else begin
            rem_r <= rem_r;
        end
    end

    assign InReady  = in_ready_s;
    assign OutValid = out_valid_r;
    assign Shifted  = shifted_r;
    assign ResUfOut = res_uf_r;

endmodule

// File: tb/tb_cvt_shift_seq.sv
// -----------------------------------------------------------------------------
// tb_cvt_shift_seq
// Directed bench for cvt_shift_seq. The driver pushes hand-computed results
// into a queue; an independent monitor pops and compares on every handshake,
// and also checks latency from accept to the first OutValid.
// -----------------------------------------------------------------------------
module tb_cvt_shift_seq;

    localparam int W  = 117;
    localparam int SW = 7;

    typedef struct {
        logic [W-1:0] s;
        logic         uf;
        int           lat;
    } exp_t;

    logic          clk;
    logic          reset_n;
    logic          Flush;
    logic          InValid;
    logic          InReady;
    logic [W-1:0]  ShiftIn;
    logic [SW-1:0] ShiftAmt;
    logic          ResUfIn;
    logic          OutValid;
    logic          OutReady;
    logic [W-1:0]  Shifted;
    logic          ResUfOut;

    int   checks;
    int   errors;
    int   cyc;
    exp_t exp_q[$];
    int   acc_q[$];
    bit   new_res;

    logic [W-1:0] one_v;
    logic [W-1:0] ones_v;

    cvt_shift_seq dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .ShiftIn  (ShiftIn),
        .ShiftAmt (ShiftAmt),
        .ResUfIn  (ResUfIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Shifted  (Shifted),
        .ResUfOut (ResUfOut)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Edge counter used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: samples 1 time unit after each falling edge
    initial begin
        new_res = 1'b1;
        forever begin
            @(negedge clk);
            #1;
            if (!reset_n) begin
                exp_q.delete();
                acc_q.delete();
                new_res = 1'b1;
            end else begin
                if (OutValid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%h required=no_output", Shifted);
                    end else begin
                        if (new_res) begin
                            if (acc_q.size() == 0) begin
                                chk("latency_no_accept", 117'd0, 117'd1);
                            end else begin
                                chk("latency", W'(cyc + 1 - acc_q[0]), W'(exp_q[0].lat));
                            end
                            new_res = 1'b0;
                        end
                        chk("shifted", Shifted, exp_q[0].s);
                        chk("res_uf", W'(ResUfOut), W'(exp_q[0].uf));
                        if (!OutReady) begin
                            chk("inready_hold", W'(InReady), 117'd0);
                        end else if (!Flush) begin
                            void'(exp_q.pop_front());
                            if (acc_q.size() != 0) void'(acc_q.pop_front());
                            new_res = 1'b1;
                        end else begin
                            new_res = new_res;
                        end
                    end
                end
                if (Flush) begin
                    acc_q.delete();
                    new_res = 1'b1;
                end
                if (InValid && InReady && !Flush) acc_q.push_back(cyc + 1);
            end
        end
    end

    // Present a request at the current falling edge and wait until accepted
    task automatic send(input logic [W-1:0] v, input logic [SW-1:0] a, input logic uf,
                        input logic [W-1:0] es, input int el, input bit push,
                        output int waited);
        int n;
        exp_t e;
        n = 0;
        ShiftIn  = v;
        ShiftAmt = a;
        ResUfIn  = uf;
        InValid  = 1'b1;
        #1;
        while (!InReady && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        waited = n;
        if (!InReady) begin
            chk("accept_timeout", 117'd0, 117'd1);
        end else if (push) begin
            e.s   = es;
            e.uf  = uf;
            e.lat = el;
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        InValid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", W'(exp_q.size()), 117'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        cyc      = 0;
        checks   = 0;
        errors   = 0;
        one_v    = 117'd1;
        ones_v   = {W{1'b1}};
        reset_n  = 1'b0;
        Flush    = 1'b0;
        InValid  = 1'b0;
        ShiftIn  = {W{1'b0}};
        ShiftAmt = 7'd0;
        ResUfIn  = 1'b0;
        OutReady = 1'b1;
        #1;
        chk("rst_outvalid", W'(OutValid), 117'd0);
        chk("rst_shifted", Shifted, 117'd0);
        chk("rst_resuf", W'(ResUfOut), 117'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_inready", W'(InReady), 117'd1);
        @(negedge clk);

        // Zero shift, then several amounts around the step boundary
        send(one_v, 7'd0, 1'b1, one_v, 1, 1'b1, w);
        drain();
        send(one_v, 7'd40, 1'b0, one_v << 40, 4, 1'b1, w);
        send(one_v, 7'd16, 1'b1, one_v << 16, 2, 1'b1, w);
        send(one_v, 7'd17, 1'b0, one_v << 17, 3, 1'b1, w);
        drain();

        // Top bit and saturation
        send(one_v, 7'd116, 1'b1, one_v << 116, 9, 1'b1, w);
        send(one_v, 7'd117, 1'b0, 117'd0, 9, 1'b1, w);
        send(one_v, 7'd127, 1'b1, 117'd0, 9, 1'b1, w);
        drain();

        // Backpressure hold, then back-to-back reload
        OutReady = 1'b0;
        send(ones_v, 7'd5, 1'b1, ones_v << 5, 2, 1'b1, w);
        repeat (6) @(negedge clk);
        OutReady = 1'b1;
        send(117'h123, 7'd0, 1'b0, 117'h123, 1, 1'b1, w);
        chk("b2b_same_cycle", W'(w), 117'd0);
        drain();

        // Flush two edges into a long shift, with a concurrent request
        send(one_v, 7'd100, 1'b0, 117'd0, 0, 1'b0, w);
        @(negedge clk);
        Flush    = 1'b1;
        InValid  = 1'b1;
        ShiftIn  = 117'd7;
        ShiftAmt = 7'd0;
        @(negedge clk);
        Flush   = 1'b0;
        InValid = 1'b0;
        #1;
        chk("flush_inready", W'(InReady), 117'd1);
        chk("flush_outvalid", W'(OutValid), 117'd0);
        repeat (12) @(negedge clk);
        // Flush in IDLE must also block an offered request
        Flush   = 1'b1;
        InValid = 1'b1;
        @(negedge clk);
        Flush   = 1'b0;
        InValid = 1'b0;
        repeat (4) @(negedge clk);
        send(117'd3, 7'd1, 1'b1, 117'd6, 2, 1'b1, w);
        drain();

        // Asynchronous reset in the middle of a shift
        send(one_v, 7'd100, 1'b0, 117'd0, 0, 1'b0, w);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_outvalid", W'(OutValid), 117'd0);
        chk("arst_shifted", Shifted, 117'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("arst_inready", W'(InReady), 117'd1);
        @(negedge clk);
        send(117'd5, 7'd3, 1'b1, 117'd40, 2, 1'b1, w);
        drain();
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
